conv_window_gen: RTL and testbench

//  Upstream feeder for the conv2d stage. Accepts a row-major pixel stream (one pixel/beat) and emits 3x3 pixel windows.
//  - Windows honour stride_x/stride_y; valid-only convolution, no padding.
//  - Each emitted window is one conv2d kernel application. Default frame is MNIST 28x28, 8-bit grey.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv_window_gen.sv | 179 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and helpers for the 3x3 convolution window generator.
package conv_pkg;

  localparam int K         = 3;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } conv_state_e;

  // Flat position of window element (row i, column j); row 0 is the oldest image row.
  function automatic int win_idx(input int i, input int j);
    return i * K + j;
  endfunction

  function automatic logic [2:0] fix_stride(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: combinational read of the old value, write on the clock edge.
module conv_line_buffer #(
  parameter  int DEPTH = 28,
  parameter  int PIX_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Contents are never reset; the frame's first two rows overwrite them before any window uses them.
  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Turns a row-major pixel stream into strided 3x3 windows for the conv2d stage (valid-only, no padding).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  parameter  int PIX_W = DEF_PIX_W,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             stride_x,
  input  logic [2:0]             stride_y,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*PIX_W-1:0]   out_window,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   out_last
);

  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

  conv_state_e state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [2:0]    sx_q, sx_d, sy_q, sy_d;
  logic [2:0]    col_ph_q, col_ph_d, row_ph_q, row_ph_d;
  logic [2:0]    col_ph_cur, row_ph_cur;
  logic [K*K-1:0][PIX_W-1:0] win_q, win_d;
  logic [K*K-1:0][PIX_W-1:0] out_win_q, out_win_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic             accept;
  logic             emit_hit;
  logic             last_hit;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_window = out_win_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

  // lb0 holds the previous row, lb1 the row before it; lb0's displaced pixel moves into lb1.
  conv_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (c_q),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (c_q),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    col_ph_d    = col_ph_q;
    row_ph_d    = row_ph_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_win_d   = out_win_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    // Phases restart at the first window-capable column/row, so phase 0 means "(pos-2) % stride == 0".
    col_ph_cur = (c_q == CW'(2)) ? 3'd0 : col_ph_q;
    row_ph_cur = (r_q == RW'(2)) ? 3'd0 : row_ph_q;

    emit_hit = (state_q == EMIT) && (r_q >= RW'(2)) && (c_q >= CW'(2)) &&
               (col_ph_cur == 3'd0) && (row_ph_cur == 3'd0);
    last_hit = ((16'(r_q) + 16'(sy_q)) > 16'(IMG_H - 1)) &&
               ((16'(c_q) + 16'(sx_q)) > 16'(IMG_W - 1));

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[win_idx(i, j)] = win_q[win_idx(i, j + 1)];
        end
      end
      win_d[win_idx(0, K - 1)] = lb1_rd;
      win_d[win_idx(1, K - 1)] = lb0_rd;
      win_d[win_idx(2, K - 1)] = in_pixel;

      col_ph_d = (col_ph_cur == sx_q - 3'd1) ? 3'd0 : col_ph_cur + 3'd1;

      if (c_q == LAST_C) begin
        c_d      = '0;
        row_ph_d = (row_ph_cur == sy_q - 3'd1) ? 3'd0 : row_ph_cur + 3'd1;
        r_d      = (r_q == LAST_R) ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end

      unique case (state_q)
        IDLE: begin
          sx_d    = fix_stride(stride_x);
          sy_d    = fix_stride(stride_y);
          state_d = FILL;
        end
        FILL: begin
          if (c_q == LAST_C && r_q == RW'(1)) state_d = EMIT;
        end
        EMIT: begin
          if (c_q == LAST_C && r_q == LAST_R) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (emit_hit) begin
        out_valid_d = 1'b1;
        out_last_d  = last_hit;
        out_win_d   = win_d;
        out_row_d   = r_q - RW'(2);
        out_col_d   = c_q - CW'(2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      sx_q        <= 3'd1;
      sy_q        <= 3'd1;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_win_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      col_ph_q    <= col_ph_d;
      row_ph_q    <= row_ph_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_win_q   <= out_win_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a direct pixel-formula model predicts each window as its pixel is accepted.
module tb_conv_window_gen;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stride_x, stride_y;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_window;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        out_last;

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    logic        last;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rx_cnt = 0;
  int   last_cnt = 0;
  bit   presented = 0;
  bit   stall_en = 0;
  bit   stall_done = 0;

  conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stride_x   (stride_x),
    .stride_y   (stride_y),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 28 + c) % 256);
  endfunction

  // Drives pixels 0..n_pix-1 of a frame; strides switch to 1/1 after pixel change_at when change_at >= 0.
  task automatic applyStimulus(input int sx_in, input int sy_in, input int n_pix, input int change_at);
    int   sxm, sym, r, c, waited;
    exp_t e;
    sxm = (sx_in == 0) ? 1 : sx_in;
    sym = (sy_in == 0) ? 1 : sy_in;
    stride_x = 3'(sx_in);
    stride_y = 3'(sy_in);
    for (int p = 0; p < n_pix; p++) begin
      r = p / IMG_W;
      c = p % IMG_W;
      in_valid = 1'b1;
      in_pixel = pix(r, c);
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      if (r >= 2 && c >= 2 && (r - 2) % sym == 0 && (c - 2) % sxm == 0) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[(i * 3 + j) * 8 +: 8] = pix(r - 2 + i, c - 2 + j);
        e.row     = r - 2;
        e.col     = c - 2;
        e.last    = ((r - 2) + sym > IMG_H - 3) && ((c - 2) + sxm > IMG_W - 3);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (p == change_at) begin
        stride_x = 3'd1;
        stride_y = 3'd1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_sb_size", sb.size(), 0);
  endtask

  task automatic startScenario();
    rx_cnt   = 0;
    last_cnt = 0;
  endtask

  // Monitor: first presentation checks latency, transfer checks content and pops.
  always @(negedge clk) begin
    if (rst) begin
      presented = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_window", sb.size(), 1);
      end else begin
        if (!presented) begin
          checkOutput("latency", cyc, sb[0].acc_cyc);
          presented = 1;
        end
        if (out_ready) begin
          checkOutput("window", out_window, sb[0].win);
          checkOutput("row", out_row, sb[0].row);
          checkOutput("col", out_col, sb[0].col);
          checkOutput("last", out_last, sb[0].last);
          if (out_last) last_cnt++;
          rx_cnt++;
          void'(sb.pop_front());
          presented = 0;
        end
      end
    end
  end

  // Back-pressure: hold out_ready low for five cycles on the first window once enabled.
  always @(posedge clk) begin
    #1;
    if (stall_en && !stall_done && out_valid) begin
      stall_done = 1;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("stall_in_ready", in_ready, 0);
        if (sb.size() > 0) checkOutput("stall_window", out_window, sb[0].win);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b1;
    stride_x = 3'd1;
    stride_y = 3'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_window", out_window, 0);
    checkOutput("rst_out_row", out_row, 0);
    checkOutput("rst_out_col", out_col, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: stride 1/1");
    startScenario();
    applyStimulus(1, 1, IMG_W * IMG_H, -1);
    waitDrain();
    checkOutput("s1_count", rx_cnt, 676);
    checkOutput("s1_last_count", last_cnt, 1);

    $display("[TB] scenario 2: stride 2/2");
    startScenario();
    applyStimulus(2, 2, IMG_W * IMG_H, -1);
    waitDrain();
    checkOutput("s2_count", rx_cnt, 169);
    checkOutput("s2_last_count", last_cnt, 1);

    $display("[TB] scenario 3: back-pressure on first window");
    startScenario();
    stall_en = 1;
    stall_done = 0;
    applyStimulus(1, 1, IMG_W * IMG_H, -1);
    waitDrain();
    stall_en = 0;
    checkOutput("s3_stall_seen", stall_done, 1);
    checkOutput("s3_count", rx_cnt, 676);
    checkOutput("s3_last_count", last_cnt, 1);

    $display("[TB] scenario 4: stride 0/0");
    startScenario();
    applyStimulus(0, 0, IMG_W * IMG_H, -1);
    waitDrain();
    checkOutput("s4_count", rx_cnt, 676);
    checkOutput("s4_last_count", last_cnt, 1);

    $display("[TB] scenario 5: reset mid-frame");
    applyStimulus(1, 1, 100, -1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s5_rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s5_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    sb.delete();
    presented = 0;
    rst = 1'b0;
    startScenario();
    @(negedge clk);
    checkOutput("s5_in_ready", in_ready, 1);
    checkOutput("s5_no_stale", out_valid, 0);
    @(posedge clk);
    #1;
    applyStimulus(1, 1, IMG_W * IMG_H, -1);
    waitDrain();
    checkOutput("s5_count", rx_cnt, 676);
    checkOutput("s5_last_count", last_cnt, 1);

    $display("[TB] scenario 6: stride 3/3 changed mid-frame, then back-to-back stride 1");
    startScenario();
    applyStimulus(3, 3, IMG_W * IMG_H, 10);
    checkOutput("s6a_sb_count", rx_cnt + sb.size(), 81);
    applyStimulus(1, 1, IMG_W * IMG_H, -1);
    waitDrain();
    checkOutput("s6_count", rx_cnt, 81 + 676);
    checkOutput("s6_last_count", last_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
